// File: rtl/cpu_alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add MUL
// and restoring DIV/MOD, behind a valid/ready request and result handshake.
module cpu_alu_mc #(
   parameter int WIDTH = 32,
   parameter int OPW   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] arg1,
   input  logic [WIDTH-1:0] arg2,
   input  logic [OPW-1:0]   opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] value,
   output logic [4:0]       flags
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [OPW-1:0] OP_ADD = OPW'('h0);
   localparam logic [OPW-1:0] OP_SUB = OPW'('h1);
   localparam logic [OPW-1:0] OP_MUL = OPW'('h2);
   localparam logic [OPW-1:0] OP_DIV = OPW'('h3);
   localparam logic [OPW-1:0] OP_MOD = OPW'('h4);
   localparam logic [OPW-1:0] OP_AND = OPW'('h5);
   localparam logic [OPW-1:0] OP_OR  = OPW'('h6);
   localparam logic [OPW-1:0] OP_XOR = OPW'('h7);
   localparam logic [OPW-1:0] OP_NOT = OPW'('h8);
   localparam logic [OPW-1:0] OP_LSH = OPW'('h9);
   localparam logic [OPW-1:0] OP_RSH = OPW'('h10);
   localparam logic [OPW-1:0] OP_ASR = OPW'('h11);

   localparam int F_ZERO = 0;
   localparam int F_CARRY = 1;
   localparam int F_OVF = 2;
   localparam int F_DZ = 3;
   localparam int F_ILL = 4;

   logic [1:0]       state_q, state_d;
   logic [OPW-1:0]   op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, val_q, val_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [4:0]       flg_q, flg_d;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH-1:0] sub_diff, sc_val;
   logic [4:0]       sc_flags;
   logic             is_multi;

   always_comb begin
      add_sum  = {1'b0, arg1} + {1'b0, arg2};
      sub_diff = arg1 - arg2;
      sc_val   = '0;
      sc_flags = '0;
      is_multi = (opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_MOD);
      case (opcode)
         OP_ADD: begin
            sc_val            = add_sum[WIDTH-1:0];
            sc_flags[F_CARRY] = add_sum[WIDTH];
            sc_flags[F_OVF]   = (arg1[WIDTH-1] == arg2[WIDTH-1]) && (add_sum[WIDTH-1] != arg1[WIDTH-1]);
         end
         OP_SUB: begin
            sc_val            = sub_diff;
            sc_flags[F_CARRY] = arg1 < arg2;
            sc_flags[F_OVF]   = (arg1[WIDTH-1] != arg2[WIDTH-1]) && (sub_diff[WIDTH-1] != arg1[WIDTH-1]);
         end
         OP_AND: sc_val = arg1 & arg2;
         OP_OR:  sc_val = arg1 | arg2;
         OP_XOR: sc_val = arg1 ^ arg2;
         OP_NOT: sc_val = ~arg1;
         // Shifts by the full arg2 value: oversized amounts flush to 0 / sign fill.
         OP_LSH: sc_val = arg1 << arg2;
         OP_RSH: sc_val = arg1 >> arg2;
         OP_ASR: sc_val = $unsigned($signed(arg1) >>> arg2);
         OP_MUL, OP_DIV, OP_MOD: sc_val = '0;
         default: sc_flags[F_ILL] = 1'b1;
      endcase
      sc_flags[F_ZERO] = (sc_val == '0);
   end

   // MUL keeps {acc_q, a_q} as the running product, multiplier shifting out of a_q.
   // DIV/MOD keep the remainder in acc_q while quotient bits shift into a_q.
   logic [WIDTH:0]   mul_sum, div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_take;

   always_comb begin
      mul_sum   = a_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};
      div_shift = {acc_q, a_q[WIDTH-1]};
      div_take  = div_shift >= {1'b0, b_q};
      div_diff  = div_shift[WIDTH-1:0] - b_q;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      flg_d   = flg_q;
      case (state_q)
         IDLE: if (in_valid) begin
            op_d  = opcode;
            a_d   = arg1;
            b_d   = arg2;
            acc_d = '0;
            cnt_d = '0;
            if (is_multi) begin
               state_d = BUSY;
            end else begin
               state_d = DONE;
               val_d   = sc_val;
               flg_d   = sc_flags;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CW'(1);
            if (op_q == OP_MUL) begin
               acc_d = mul_sum[WIDTH:1];
               a_d   = {mul_sum[0], a_q[WIDTH-1:1]};
            end else begin
               acc_d = div_take ? div_diff : div_shift[WIDTH-1:0];
               a_d   = {a_q[WIDTH-2:0], div_take};
            end
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = DONE;
               flg_d   = '0;
               if (op_q == OP_MUL) begin
                  val_d          = a_d;
                  flg_d[F_CARRY] = |acc_d;
               end else begin
                  // A zero divisor always "takes", leaving all-ones quotient and arg1 remainder.
                  val_d       = (op_q == OP_DIV) ? a_d : acc_d;
                  flg_d[F_DZ] = (b_q == '0);
               end
               flg_d[F_ZERO] = (val_d == '0);
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         val_q   <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         flg_q   <= flg_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign value     = val_q;
   assign flags     = flg_q;

endmodule

// File: tb/tb_cpu_alu_mc.sv
// Directed + scoreboard bench for cpu_alu_mc at WIDTH=32.
module tb_cpu_alu_mc;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] arg1, arg2, value;
   logic [15:0] opcode;
   logic [4:0]  flags;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [4:0] FZ = 5'b00001, FC = 5'b00010, FO = 5'b00100,
                          FD = 5'b01000, FI = 5'b10000;

   typedef struct {
      logic [31:0] v;
      logic [4:0]  f;
      int          lat;
   } exp_t;

   exp_t sb[$];

   cpu_alu_mc #(.WIDTH(32), .OPW(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .arg1(arg1), .arg2(arg2), .opcode(opcode), .out_valid(out_valid),
      .out_ready(out_ready), .value(value), .flags(flags)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [31:0] v, input logic [4:0] f, input int lat);
      exp_t e;
      e.v = v; e.f = f; e.lat = lat;
      return e;
   endfunction

   // Independent reference using wide arithmetic and native operators.
   function automatic exp_t model(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [63:0] w;
      longint sa, sb_, s;
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      e.v = '0; e.f = '0; e.lat = 1;
      case (op)
         16'h0: begin
            w = {32'd0, a} + {32'd0, b}; e.v = w[31:0]; e.f[1] = w[32];
            s = sa + sb_; e.f[2] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         16'h1: begin
            e.v = a - b; e.f[1] = a < b;
            s = sa - sb_; e.f[2] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         16'h2: begin w = {32'd0, a} * {32'd0, b}; e.v = w[31:0]; e.f[1] = (w[63:32] != 0); e.lat = 33; end
         16'h3: begin e.lat = 33; if (b == 0) begin e.v = 32'hFFFFFFFF; e.f[3] = 1; end else e.v = a / b; end
         16'h4: begin e.lat = 33; if (b == 0) begin e.v = a; e.f[3] = 1; end else e.v = a % b; end
         16'h5: e.v = a & b;
         16'h6: e.v = a | b;
         16'h7: e.v = a ^ b;
         16'h8: e.v = ~a;
         16'h9: e.v = (b >= 32) ? 32'd0 : a << b;
         16'h10: e.v = (b >= 32) ? 32'd0 : a >> b;
         16'h11: e.v = (b >= 32) ? {32{a[31]}} : $unsigned($signed(a) >>> b);
         default: e.f[4] = 1;
      endcase
      e.f[0] = (e.v == 0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with out_valid high; leaves at posedge+1 in IDLE.
   task automatic release_done(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk({tag, ".idle_rdy"}, in_ready, 1);
      chk({tag, ".idle_ov"}, out_valid, 0);
   endtask

   task automatic go(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b,
                     input exp_t e, input string tag, input bit rel);
      int   lat;
      exp_t x;
      @(negedge clk);
      chk({tag, ".in_ready"}, in_ready, 1);
      opcode = op; arg1 = a; arg2 = b; in_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
      arg1 = $urandom; arg2 = $urandom; opcode = 16'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 1, 0);
      end else begin
         x = sb.pop_front();
         chk({tag, ".lat"}, lat, x.lat);
         chk({tag, ".value"}, value, x.v);
         chk({tag, ".flags"}, flags, x.f);
      end
      if (rel) release_done(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ops [14];
      logic [31:0] ra, rb;
      logic [15:0] ro;
      ops = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7,
              16'h8, 16'h9, 16'h10, 16'h11, 16'h0C, 16'h12};

      rst_n = 1'b0; out_ready = 1'b0;
      in_valid = 1'b1; opcode = 16'h0; arg1 = 32'd7; arg2 = 32'd9;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.in_ready", in_ready, 1);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.value", value, 0);
      chk("rst.flags", flags, 0);
      in_valid = 1'b0;
      rst_n = 1'b1;

      go(16'h0, 32'hFFFFFFFF, 32'h1, mk(32'h0, FZ | FC, 1), "add_wrap", 1);
      go(16'h2, 32'h10000, 32'h10003, mk(32'h30000, FC, 33), "mul_hi", 1);
      go(16'h3, 32'd100, 32'd7, mk(32'd14, 5'b0, 33), "div", 1);
      go(16'h4, 32'd100, 32'd7, mk(32'd2, 5'b0, 33), "mod", 1);
      go(16'h3, 32'd5, 32'd0, mk(32'hFFFFFFFF, FD, 33), "div0", 1);
      go(16'h4, 32'd5, 32'd0, mk(32'd5, FD, 33), "mod0", 1);
      go(16'h11, 32'h80000000, 32'd40, mk(32'hFFFFFFFF, 5'b0, 1), "asr40", 1);
      go(16'h10, 32'h80000000, 32'd40, mk(32'h0, FZ, 1), "rsh40", 1);
      go(16'h12, 32'h1234, 32'h5678, mk(32'h0, FI | FZ, 1), "ill12", 1);
      go(16'h0A, 32'h1, 32'h1, mk(32'h0, FI | FZ, 1), "ill0a", 1);
      go(16'h1, 32'd3, 32'd5, mk(32'hFFFFFFFE, FC, 1), "sub_borrow", 1);
      go(16'h0, 32'h7FFFFFFF, 32'h1, mk(32'h80000000, FO, 1), "add_ovf", 1);
      go(16'h1, 32'h80000000, 32'h1, mk(32'h7FFFFFFF, FO, 1), "sub_ovf", 1);
      go(16'h8, 32'h0, 32'h0, mk(32'hFFFFFFFF, 5'b0, 1), "not", 1);
      go(16'h9, 32'h1, 32'd31, mk(32'h80000000, 5'b0, 1), "lsh31", 1);
      go(16'h9, 32'h1, 32'd32, mk(32'h0, FZ, 1), "lsh32", 1);
      go(16'h11, 32'h80000000, 32'd4, mk(32'hF8000000, 5'b0, 1), "asr4", 1);
      go(16'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'h1, FC, 33), "mul_max", 1);
      go(16'h2, 32'd0, 32'd12345, mk(32'h0, FZ, 33), "mul_zero", 1);
      go(16'h3, 32'hFFFFFFFF, 32'd1, mk(32'hFFFFFFFF, 5'b0, 33), "div_by1", 1);

      for (int i = 0; i < 12; i++) begin
         ro = ops[$urandom_range(0, 13)];
         ra = $urandom;
         rb = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         go(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d_op%0h", i, ro), 1);
      end

      // Hold the result with out_ready low while in_valid toggles.
      go(16'h5, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'hF000F000, 5'b0, 1), "hold", 0);
      for (int i = 0; i < 10; i++) begin
         in_valid = ~in_valid; opcode = 16'h0; arg1 = 32'd1; arg2 = 32'd1;
         @(negedge clk);
         chk($sformatf("hold%0d.value", i), value, 32'hF000F000);
         chk($sformatf("hold%0d.flags", i), flags, 5'b0);
         chk($sformatf("hold%0d.in_ready", i), in_ready, 0);
         chk($sformatf("hold%0d.out_valid", i), out_valid, 1);
      end
      in_valid = 1'b0;
      release_done("hold");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("hold_noextra%0d", i), out_valid, 0);
      end

      // Reset in the middle of a division aborts it without a result.
      @(negedge clk);
      opcode = 16'h3; arg1 = 32'd1000; arg2 = 32'd3; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (16) @(posedge clk);
      @(negedge clk);
      chk("abort.busy_ready", in_ready, 0);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort.out_valid", out_valid, 0);
      chk("abort.in_ready", in_ready, 1);
      chk("abort.value", value, 0);
      chk("abort.flags", flags, 0);
      rst_n = 1'b1;
      go(16'h0, 32'd2, 32'd3, mk(32'd5, 5'b0, 1), "post_rst_add", 1);
      chk("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
